ws2812_tx: RTL and testbench

WS2812_TX -- requirements
Module: ws2812_tx

---
 rtl/ws2812_tx.sv | 129 ++++++++++++
 tb/tb_ws2812_tx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_tx.sv
// WS2812 single-wire LED transmitter: serialises one GRB pixel per handshake,
// MSB first, and inserts the chain latch gap after the last LED of a frame.
module ws2812_tx #(
   parameter int T0H      = 13,
   parameter int T1H      = 26,
   parameter int TBIT     = 40,
   parameter int TRST     = 2560,
   parameter int NUM_LEDS = 1
) (
   input  logic        clk32,
   input  logic        reset_n,
   input  logic [23:0] rgb,
   input  logic        valid,
   output logic        ready,
   output logic        ws2812,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, HIGH, LOW, LATCH} state_t;

   // Phase lengths are stored minus one so the timer ends a phase on zero.
   localparam logic [11:0] T0H_M1   = 12'(T0H - 1);
   localparam logic [11:0] T1H_M1   = 12'(T1H - 1);
   localparam logic [11:0] T0L_M1   = 12'(TBIT - T0H - 1);
   localparam logic [11:0] T1L_M1   = 12'(TBIT - T1H - 1);
   localparam logic [11:0] TRST_M1  = 12'(TRST - 1);
   localparam logic [11:0] TRST_C   = 12'(TRST);
   localparam logic [7:0]  LAST_LED = 8'(NUM_LEDS - 1);

   state_t      state_q;
   logic [23:0] shift_q;
   logic [4:0]  bit_cnt_q;
   logic [11:0] phase_q;
   logic [7:0]  led_cnt_q;
   logic [11:0] idle_q;
   logic        ready_q;
   logic        ws2812_q;
   logic        busy_q;

   always_ff @(posedge clk32 or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         phase_q   <= '0;
         led_cnt_q <= '0;
         idle_q    <= '0;
         ready_q   <= 1'b0;
         ws2812_q  <= 1'b0;
         busy_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (valid && ready_q) begin
                  shift_q   <= rgb;
                  bit_cnt_q <= 5'd23;
                  phase_q   <= rgb[23] ? T1H_M1 : T0H_M1;
                  idle_q    <= '0;
                  state_q   <= HIGH;
                  ready_q   <= 1'b0;
                  busy_q    <= 1'b1;
                  ws2812_q  <= 1'b1;
               end else begin
                  ready_q <= 1'b1;
                  // A full reset-length low time in IDLE means the chain has latched.
                  if (idle_q != TRST_C) begin
                     idle_q <= idle_q + 12'd1;
                     if (idle_q == TRST_M1) begin
                        led_cnt_q <= '0;
                     end
                  end
               end
            end

            HIGH: begin
               if (phase_q == 12'd0) begin
                  state_q  <= LOW;
                  ws2812_q <= 1'b0;
                  phase_q  <= shift_q[23] ? T1L_M1 : T0L_M1;
               end else begin
                  phase_q <= phase_q - 12'd1;
               end
            end

            LOW: begin
               if (phase_q == 12'd0) begin
                  if (bit_cnt_q != 5'd0) begin
                     shift_q   <= {shift_q[22:0], 1'b0};
                     bit_cnt_q <= bit_cnt_q - 5'd1;
                     phase_q   <= shift_q[22] ? T1H_M1 : T0H_M1;
                     state_q   <= HIGH;
                     ws2812_q  <= 1'b1;
                  end else if (led_cnt_q == LAST_LED) begin
                     phase_q <= TRST_M1;
                     state_q <= LATCH;
                  end else begin
                     led_cnt_q <= led_cnt_q + 8'd1;
                     state_q   <= IDLE;
                     busy_q    <= 1'b0;
                     ready_q   <= 1'b1;
                  end
               end else begin
                  phase_q <= phase_q - 12'd1;
               end
            end

            LATCH: begin
               if (phase_q == 12'd0) begin
                  led_cnt_q <= '0;
                  state_q   <= IDLE;
                  busy_q    <= 1'b0;
                  ready_q   <= 1'b1;
               end else begin
                  phase_q <= phase_q - 12'd1;
               end
            end

            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ready  = ready_q;
   assign ws2812 = ws2812_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_ws2812_tx.sv
// Bench for ws2812_tx: two chains (1 LED and 3 LEDs) checked every cycle against
// a waveform model built from pixel bits, plus hand-computed timing literals.
module tb_ws2812_tx;

   localparam int T0H  = 13;
   localparam int T1H  = 26;
   localparam int TBIT = 40;
   localparam int TRST = 2560;

   logic             clk;
   logic             rst_n;
   logic [1:0][23:0] rgb_v;
   logic [1:0]       valid_v;
   logic [1:0]       rdy_v;
   logic [1:0]       ws_v;
   logic [1:0]       busy_v;

   int tests;
   int fails;

   ws2812_tx #(.NUM_LEDS(1)) u_dut0 (
      .clk32(clk), .reset_n(rst_n), .rgb(rgb_v[0]), .valid(valid_v[0]),
      .ready(rdy_v[0]), .ws2812(ws_v[0]), .busy(busy_v[0])
   );

   ws2812_tx #(.NUM_LEDS(3)) u_dut1 (
      .clk32(clk), .reset_n(rst_n), .rgb(rgb_v[1]), .valid(valid_v[1]),
      .ready(rdy_v[1]), .ws2812(ws_v[1]), .busy(busy_v[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Model: expected line waveform per accepted pixel, replayed cycle by cycle.
   bit wave [2][0:3599];
   int mpos [2];
   int mlen [2];
   int mled [2];
   int midle[2];
   bit mready[2];

   // Observed events used by the literal timing checks.
   int cyc;
   int acc_t[2][0:31];
   int acc_n[2];
   int fall_t[2];
   bit prev_busy[2];

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic build(input int d, input logic [23:0] p);
      int n;
      int h;
      int nl;
      n = 0;
      for (int b = 23; b >= 0; b--) begin
         h = p[b] ? T1H : T0H;
         for (int k = 0; k < TBIT; k++) begin
            wave[d][n] = (k < h);
            n++;
         end
      end
      nl = (d == 0) ? 1 : 3;
      if (mled[d] == nl - 1) begin
         for (int k = 0; k < TRST; k++) begin
            wave[d][n] = 1'b0;
            n++;
         end
         mled[d] = 0;
      end else begin
         mled[d] = mled[d] + 1;
      end
      mlen[d]  = n;
      mpos[d]  = 0;
      midle[d] = 0;
   endtask

   initial begin
      logic e_ws, e_busy, e_rdy;
      cyc = 0;
      for (int d = 0; d < 2; d++) begin
         mpos[d] = 0; mlen[d] = 0; mled[d] = 0; midle[d] = 0; mready[d] = 0;
         acc_n[d] = 0; fall_t[d] = 0; prev_busy[d] = 0;
      end
      forever begin
         @(negedge clk);
         cyc++;
         for (int d = 0; d < 2; d++) begin
            if (!rst_n) begin
               e_ws = 0; e_busy = 0; e_rdy = 0;
               mpos[d] = 0; mlen[d] = 0; mready[d] = 0; mled[d] = 0; midle[d] = 0;
            end else if (mpos[d] < mlen[d]) begin
               e_ws = wave[d][mpos[d]]; e_busy = 1; e_rdy = 0;
            end else begin
               e_ws = 0; e_busy = 0; e_rdy = mready[d];
            end
            tests++;
            if ({ws_v[d], busy_v[d], rdy_v[d]} !== {e_ws, e_busy, e_rdy}) begin
               fails++;
               if (fails <= 30)
                  $display("FAIL cycle_check dut%0d cyc %0d: ws/busy/ready=%b%b%b expected %b%b%b",
                           d, cyc, ws_v[d], busy_v[d], rdy_v[d], e_ws, e_busy, e_rdy);
            end
            if (rst_n && rdy_v[d] && valid_v[d]) begin
               $display("[TB] dut%0d accepted pixel %06h at cycle %0d", d, rgb_v[d], cyc);
               if (acc_n[d] < 32) begin
                  acc_t[d][acc_n[d]] = cyc;
                  acc_n[d] = acc_n[d] + 1;
               end
            end
            if (prev_busy[d] && !busy_v[d]) fall_t[d] = cyc;
            prev_busy[d] = busy_v[d];
            if (rst_n) begin
               if (mpos[d] < mlen[d]) begin
                  mpos[d] = mpos[d] + 1;
               end else begin
                  if (mready[d] && valid_v[d]) begin
                     build(d, rgb_v[d]);
                  end else if (midle[d] < TRST) begin
                     midle[d] = midle[d] + 1;
                     if (midle[d] == TRST) mled[d] = 0;
                  end
                  mready[d] = 1;
               end
            end
         end
      end
   end

   task automatic wait_acc(input int d, input int k);
      int t;
      t = 0;
      while (acc_n[d] < k && t < 20000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wait_accept", int'(acc_n[d] >= k), 1);
   endtask

   task automatic wait_idle(input int d);
      int t;
      t = 0;
      while (busy_v[d] !== 1'b0 && t < 10000) begin
         @(posedge clk); #1;
         t++;
      end
      chk("wait_idle", int'(busy_v[d]), 0);
      @(negedge clk); #1;
   endtask

   task automatic send(input int d, input logic [23:0] p);
      int k0;
      k0 = acc_n[d];
      @(posedge clk); #1;
      rgb_v[d]   = p;
      valid_v[d] = 1'b1;
      wait_acc(d, k0 + 1);
      valid_v[d] = 1'b0;
   endtask

   // Counts negedges while the line is at lvl (busy only) or, with use_busy, while busy.
   task automatic meas(input int d, input logic lvl, input bit use_busy, output int n);
      n = 0;
      while (n < 5000 && (use_busy ? (busy_v[d] === 1'b1)
                                   : (ws_v[d] === lvl && busy_v[d] === 1'b1))) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic triple(input int d, input logic [23:0] a, input logic [23:0] b,
                         input logic [23:0] c, input string tag);
      int k0;
      k0 = acc_n[d];
      @(posedge clk); #1;
      rgb_v[d] = a; valid_v[d] = 1'b1;
      wait_acc(d, k0 + 1);
      rgb_v[d] = b;
      wait_acc(d, k0 + 2);
      rgb_v[d] = c;
      wait_acc(d, k0 + 3);
      valid_v[d] = 1'b0;
      rgb_v[d]   = 24'h13579B;
      wait_idle(d);
      chk({tag, "_gap12"}, acc_t[d][k0 + 1] - acc_t[d][k0], 961);
      chk({tag, "_gap23"}, acc_t[d][k0 + 2] - acc_t[d][k0 + 1], 961);
      chk({tag, "_latch_end"}, fall_t[d] - acc_t[d][k0 + 2], 3521);
   endtask

   initial begin
      int h0, l0, h1, rest, h, l, cnt13, lasth, sum;
      tests = 0; fails = 0;
      rst_n = 1'b0; valid_v = '0; rgb_v = '0;

      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      chk("reset_outputs", int'({ws_v, busy_v, rdy_v}), 0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      #1;
      chk("ready_at_release", int'(rdy_v), 0);
      @(posedge clk); #1;
      chk("ready_first_edge", int'(rdy_v), 3);

      // One-LED chain, MSB-only pixel; rgb changes right after acceptance.
      send(0, 24'h800000);
      rgb_v[0] = 24'h7FFFFF;
      @(negedge clk);
      meas(0, 1'b1, 1'b0, h0);
      meas(0, 1'b0, 1'b0, l0);
      meas(0, 1'b1, 1'b0, h1);
      meas(0, 1'b0, 1'b1, rest);
      chk("p800000_first_high", h0, 26);
      chk("p800000_first_low", l0, 14);
      chk("p800000_second_high", h1, 13);
      chk("p800000_busy_total", h0 + l0 + h1 + rest, 3520);
      chk("p800000_ready_after", int'(rdy_v[0]), 1);

      // LSB-only pixel: 23 short pulses, long last pulse, then latch.
      send(0, 24'h000001);
      rgb_v[0] = 24'hFFFFFE;
      @(negedge clk);
      cnt13 = 0; lasth = 0; sum = 0;
      for (int b = 0; b < 24; b++) begin
         meas(0, 1'b1, 1'b0, h);
         meas(0, 1'b0, 1'b0, l);
         if (b < 23) cnt13 += (h == 13) ? 1 : 0;
         else lasth = h;
         sum += h + l;
      end
      chk("p000001_short_pulses", cnt13, 23);
      chk("p000001_last_high", lasth, 26);
      chk("p000001_pixel_plus_latch", sum, 3520);

      // Three-LED chain with valid held: latch only after the third pixel.
      triple(1, 24'hFF00A5, 24'h00FF5A, 24'h0F0F0F, "hold3");

      // One pixel, idle long enough to latch, then three more.
      send(1, 24'hC3C3C3);
      wait_idle(1);
      repeat (2600) @(posedge clk);
      triple(1, 24'h123456, 24'hABCDEF, 24'h654321, "relatch");

      // Reset during bit 10 HIGH phase, then a complete pixel.
      send(0, 24'hAAAAAA);
      repeat (523) @(posedge clk);
      #1;
      chk("abort_ws_before", int'(ws_v[0]), 1);
      rst_n = 1'b0;
      #1;
      chk("abort_ws_low", int'(ws_v[0]), 0);
      chk("abort_busy_low", int'(busy_v[0]), 0);
      chk("abort_ready_low", int'(rdy_v[0]), 0);
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      #1;
      chk("abort_ready_at_release", int'(rdy_v[0]), 0);
      @(posedge clk); #1;
      chk("abort_ready_after_edge", int'(rdy_v[0]), 1);
      send(0, 24'h5A5A5A);
      wait_idle(0);
      chk("after_abort_full_pixel", fall_t[0] - acc_t[0][acc_n[0] - 1], 3521);

      repeat (5) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #1000000;
      fails++;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
